sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// 2:1 arbiter sharing one SRAM-like memory port between instruction and data masters.
// Define ARB_ROUND_ROBIN_EN to alternate the tie-break instead of fixed data-over-inst priority.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state, state_nx;
    logic   owner, owner_nx;   // 0 = inst, 1 = data
    logic   winner, any_req, sel;
    logic   grant_ok, resp_ok;

    assign any_req = inst_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last, rr_last_nx;

    always_comb begin
        winner = (inst_req && data_req) ? ~rr_last : data_req;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_last <= 1'b0;
        else     rr_last <= rr_last_nx;
    end
`else
    always_comb begin
        winner = data_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_nx = rr_last;
`endif
        sel      = owner;
        mem_req  = 1'b0;
        grant_ok = 1'b0;
        resp_ok  = 1'b0;
        case (state)
            IDLE: begin
                sel = winner;
                if (any_req) begin
                    mem_req  = 1'b1;
                    owner_nx = winner;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_nx = winner;
`endif
                    grant_ok = mem_addr_ok;
                    state_nx = mem_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                mem_req  = 1'b1;
                grant_ok = mem_addr_ok;
                if (mem_addr_ok) state_nx = DATA;
            end
            DATA: begin
                resp_ok = mem_data_ok;
                if (mem_data_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset masks every handshake so an aborted transaction never completes.
        if (rst) begin
            mem_req  = 1'b0;
            grant_ok = 1'b0;
            resp_ok  = 1'b0;
        end
    end

    assign mem_wr    = sel ? data_wr    : inst_wr;
    assign mem_size  = sel ? data_size  : inst_size;
    assign mem_addr  = sel ? data_addr  : inst_addr;
    assign mem_wdata = sel ? data_wdata : inst_wdata;

    assign inst_addr_ok = grant_ok & ~sel;
    assign data_addr_ok = grant_ok &  sel;
    assign inst_data_ok = resp_ok  & ~owner;
    assign data_data_ok = resp_ok  &  owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios then random traffic,
// checked each cycle against a transaction-level model of the shared port.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;

    logic        stall, stray, resp_v;
    logic [31:0] resp_data;
    logic [31:0] rom [16];

    int passes = 0;
    int total  = 0;

    // model state: -1 = nobody
    int locked   = -1;
    int inflight = -1;
    int rr_prev  = 0;
    logic [31:0] inflight_addr;
    bit acc_i, acc_d, reissue_i, reissue_d;
    int grants[$];

    always #5 clk = ~clk;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    // slave: combinational accept unless stalled, data one cycle later; not reset on purpose
    assign mem_addr_ok = mem_req && !stall;
    assign mem_data_ok = resp_v | stray;
    assign mem_rdata   = resp_data;
    always @(posedge clk) begin
        resp_v    <= mem_req && mem_addr_ok;
        resp_data <= rom[mem_addr[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int arb(input bit i, input bit d, input int last);
        if (i && d) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        if (d) return 1;
        if (i) return 0;
        return -1;
    endfunction

    // one clock: check at negedge, advance model, return at posedge+1 for driving
    task automatic step();
        int who;
        bit e_req;
        bit e_aok [2];
        bit e_dok [2];
        @(negedge clk);
        who = -1; e_req = 0;
        e_aok[0] = 0; e_aok[1] = 0; e_dok[0] = 0; e_dok[1] = 0;
        if (!rst) begin
            if (inflight >= 0) begin
                e_dok[inflight] = mem_data_ok;
            end else begin
                who = (locked >= 0) ? locked : arb(inst_req, data_req, rr_prev);
                if (who >= 0) begin
                    e_req = 1;
                    e_aok[who] = !stall;
                end
            end
        end
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_aok[0]});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_aok[1]});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_dok[0]});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_dok[1]});
        if (e_req) begin
            chk("mem_addr",  mem_addr,  who == 1 ? data_addr  : inst_addr);
            chk("mem_wdata", mem_wdata, who == 1 ? data_wdata : inst_wdata);
            chk("mem_ctl", {29'd0, mem_wr, mem_size},
                who == 1 ? {29'd0, data_wr, data_size} : {29'd0, inst_wr, inst_size});
        end
        if (e_dok[0] || e_dok[1]) begin
            chk("rdata_value", e_dok[0] ? inst_rdata : data_rdata, rom[inflight_addr[5:2]]);
        end
        chk("rdata_route", {inst_rdata ^ mem_rdata} | {data_rdata ^ mem_rdata}, 32'd0);
        acc_i = e_aok[0];
        acc_d = e_aok[1];
        if (rst) begin
            locked = -1; inflight = -1; rr_prev = 0;
        end else if (inflight >= 0) begin
            if (mem_data_ok) inflight = -1;
        end else if (who >= 0) begin
            if (locked < 0) begin
                grants.push_back(who);
                rr_prev = who;
            end
            if (!stall) begin
                inflight      = who;
                inflight_addr = (who == 1) ? data_addr : inst_addr;
                locked        = -1;
            end else begin
                locked = who;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_inst();
        inst_req = 1; inst_wr = 1'($urandom_range(1)); inst_size = 2'($urandom_range(2));
        inst_addr = {26'd0, 4'($urandom_range(15)), 2'b00}; inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_req = 1; data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(2));
        data_addr = {26'd0, 4'($urandom_range(15)), 2'b00}; data_wdata = $urandom;
    endtask

    // step, then masters drop or re-issue once their address was taken
    task automatic cyc();
        step();
        if (acc_i) begin
            if (reissue_i) new_inst(); else inst_req = 0;
        end
        if (acc_d) begin
            if (reissue_d) new_data(); else data_req = 0;
        end
    endtask

    task automatic chk_grants(input string tag, input int g0, input int g1, input int g2, input int g3, input int n);
        int exp_g [4];
        exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2; exp_g[3] = g3;
        chk({tag, "_count"}, 32'(grants.size() >= n), 32'd1);
        for (int k = 0; k < n && k < grants.size(); k++)
            chk({tag, "_order"}, 32'(grants[k]), 32'(exp_g[k]));
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = $urandom;
        rom[1] = 32'h2402_0001;
        rst = 1; stall = 0; stray = 0; reissue_i = 0; reissue_d = 0;
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h4; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2; data_addr = 0; data_wdata = 0;

        // reset held with a pending fetch
        cyc(); cyc();

        // single fetch of rom[1]
        rst = 0;
        cyc();
        chk("fetch_accept", {31'd0, acc_i}, 32'd1);
        cyc();
        chk("fetch_word", rom[inflight_addr[5:2]], 32'h2402_0001);
        cyc();

        // collision: data wins, inst follows
        grants.delete();
        inst_req = 1; inst_addr = 32'h0; data_req = 1; data_addr = 32'h8;
        repeat (5) cyc();
        chk_grants("collision", 1, 0, 0, 0, 2);

        // slow slave: inst locked while data arrives later
        grants.delete();
        inst_req = 1; inst_addr = 32'hC; stall = 1;
        cyc();
        data_req = 1; data_addr = 32'h10;
        cyc(); cyc();
        stall = 0;
        repeat (5) cyc();
        chk_grants("slow", 0, 1, 0, 0, 2);

        // reset during data phase, then a stray data_ok while idle
        inst_req = 1; inst_addr = 32'h14;
        cyc();
        rst = 1;
        cyc();
        rst = 0; stray = 1;
        cyc();
        stray = 0; data_req = 1; data_addr = 32'h18;
        repeat (3) cyc();

        // both masters requesting continuously after a fresh reset
        rst = 1;
        cyc();
        rst = 0; grants.delete(); reissue_i = 1; reissue_d = 1;
        new_inst(); new_data();
        repeat (8) cyc();
`ifdef ARB_ROUND_ROBIN_EN
        chk_grants("continuous", 1, 0, 1, 0, 4);
`else
        chk_grants("continuous", 1, 1, 1, 1, 4);
`endif
        reissue_i = 0; reissue_d = 0;
        repeat (3) cyc();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(3) == 0);
            stray = ($urandom_range(15) == 0);
            rst   = ($urandom_range(63) == 0);
            reissue_i = 1'($urandom_range(1));
            reissue_d = 1'($urandom_range(1));
            if (!inst_req && $urandom_range(2) == 0) new_inst();
            if (!data_req && $urandom_range(2) == 0) new_data();
            cyc();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
